// File: rtl/spi_pkg.sv
// Shared definitions for the SPI memory slave transaction controller:
// state encodings, default phase length and R/W flag polarity.
package spi_pkg;

    localparam int XFER_BITS_DEFAULT = 8;

    // Value of shift-register bit 0 that requests a read.
    localparam logic FLAG_READ = 1'b1;

    typedef logic [3:0] state_t;

    localparam state_t IDLE         = 4'd0;
    localparam state_t GET_ADDR     = 4'd1;
    localparam state_t LATCH_ADDR   = 4'd2;
    localparam state_t READ_WAIT    = 4'd3;
    localparam state_t READ_LOAD    = 4'd4;
    localparam state_t READ_SHIFT   = 4'd5;
    localparam state_t WRITE_SHIFT  = 4'd6;
    localparam state_t WRITE_COMMIT = 4'd7;
    localparam state_t DONE         = 4'd8;

endpackage

// File: rtl/spi_bitcounter.sv
// Bit counter for SPI phases: synchronous clear, gated increment that
// saturates at XFER_BITS, and a done flag while the count sits at XFER_BITS.
module spi_bitcounter #(
    parameter int XFER_BITS = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(XFER_BITS);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != LIMIT)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign done = (count == LIMIT);

endmodule

// File: rtl/spi_fsm.sv
// SPI memory slave transaction controller (address phase, then read or write
// data phase). Define SPI_FSM_XFER_COUNT_EN to add the completed-transaction counter.
module spi_fsm
    import spi_pkg::*;
#(
    parameter int XFER_BITS = XFER_BITS_DEFAULT,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk_posedge,
    input  logic       sclk_negedge,
    input  logic       cs,
    input  logic       rw_flag,
    output logic       addr_we,
    output logic       sr_we,
    output logic       dm_we,
    output logic       miso_buff
`ifdef SPI_FSM_XFER_COUNT_EN
    ,
    output logic [7:0] xfer_count
`endif
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(XFER_BITS - 1);

    state_t           state;
    state_t           state_next;
    logic             cnt_clear;
    logic             cnt_inc;
    logic             cnt_done;
    logic             cnt_last;
    logic [CNT_W-1:0] bit_cnt;

    spi_bitcounter #(
        .XFER_BITS (XFER_BITS),
        .CNT_W     (CNT_W)
    ) u_bitcounter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .count (bit_cnt),
        .done  (cnt_done)
    );

    assign cnt_inc = sclk_posedge &&
                     ((state == GET_ADDR) || (state == READ_SHIFT) || (state == WRITE_SHIFT));

    // Leave a shift phase on the same edge that registers its final bit.
    assign cnt_last = cnt_inc && (bit_cnt == LAST);

    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        if ((state != IDLE) && cs) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!cs) begin
                        state_next = GET_ADDR;
                        cnt_clear  = 1'b1;
                    end
                end
                GET_ADDR: begin
                    if (cnt_last) state_next = LATCH_ADDR;
                end
                LATCH_ADDR: begin
                    if (rw_flag == FLAG_READ) begin
                        state_next = READ_WAIT;
                    end else begin
                        state_next = WRITE_SHIFT;
                        cnt_clear  = 1'b1;
                    end
                end
                READ_WAIT: state_next = READ_LOAD;
                READ_LOAD: begin
                    state_next = READ_SHIFT;
                    cnt_clear  = 1'b1;
                end
                // Keep MISO driven through the hold edge of the last bit.
                READ_SHIFT: begin
                    if (cnt_done && sclk_negedge) state_next = DONE;
                end
                WRITE_SHIFT: begin
                    if (cnt_last) state_next = WRITE_COMMIT;
                end
                WRITE_COMMIT: state_next = DONE;
                DONE:         state_next = DONE;
                default:      state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign addr_we   = (state == LATCH_ADDR);
    assign sr_we     = (state == READ_LOAD);
    assign dm_we     = (state == WRITE_COMMIT);
    assign miso_buff = (state == READ_SHIFT);

`ifdef SPI_FSM_XFER_COUNT_EN
    // Only normal entry into DONE counts; aborts go straight to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_count <= '0;
        end else if ((state_next == DONE) && (state != DONE)) begin
            xfer_count <= xfer_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_fsm.sv
// Directed bench for spi_fsm: write, read, abort, stray edges, back-to-back
// transactions and mid-transaction reset, with a bench-side shift-register model.
module tb_spi_fsm;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       sclk_posedge;
    logic       sclk_negedge;
    logic       cs;
    logic       rw_flag;
    logic       addr_we;
    logic       sr_we;
    logic       dm_we;
    logic       miso_buff;
`ifdef SPI_FSM_XFER_COUNT_EN
    logic [7:0] xfer_count;
`endif

    int total = 0;
    int passed = 0;
    int fails = 0;
    int cyc_n = 0;
    int addr_n, sr_n, dm_n, miso_n;
    int addr_t, sr_t, dm_t, miso_first, miso_last;
    int last_pos = 0;
    int p8, p16;
    logic [7:0] sr_model = 8'h00;
    logic       mosi = 1'b0;

    always #5 clk = ~clk;

    spi_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .sclk_posedge (sclk_posedge),
        .sclk_negedge (sclk_negedge),
        .cs           (cs),
        .rw_flag      (rw_flag),
        .addr_we      (addr_we),
        .sr_we        (sr_we),
        .dm_we        (dm_we),
        .miso_buff    (miso_buff)
`ifdef SPI_FSM_XFER_COUNT_EN
        ,
        .xfer_count   (xfer_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rec_clear();
        addr_n = 0; sr_n = 0; dm_n = 0; miso_n = 0;
        addr_t = -1; sr_t = -1; dm_t = -1; miso_first = -1; miso_last = -1;
    endtask

    // One clk cycle with the given SCLK edge pulses; outputs sampled 1 time unit after the edge.
    task automatic cyc(input logic p, input logic n);
        sclk_posedge = p;
        sclk_negedge = n;
        @(posedge clk);
        #1;
        sclk_posedge = 1'b0;
        sclk_negedge = 1'b0;
        cyc_n++;
        if (p) begin
            sr_model = {sr_model[6:0], mosi};
            rw_flag  = sr_model[0];
            last_pos = cyc_n;
        end
        if (addr_we)   begin addr_n++; addr_t = cyc_n; end
        if (sr_we)     begin sr_n++;   sr_t   = cyc_n; end
        if (dm_we)     begin dm_n++;   dm_t   = cyc_n; end
        if (miso_buff) begin
            if (miso_n == 0) miso_first = cyc_n;
            miso_n++;
            miso_last = cyc_n;
        end
        chk("strobe_excl", 32'((addr_we & sr_we) | (addr_we & dm_we) | (sr_we & dm_we)), 32'd0);
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic check_write(input string tag);
        chk({tag, "_addr_n"}, addr_n, 1);
        chk({tag, "_addr_t"}, addr_t, p8);
        chk({tag, "_dm_n"},   dm_n,   1);
        chk({tag, "_dm_t"},   dm_t,   p16);
        chk({tag, "_sr_n"},   sr_n,   0);
        chk({tag, "_miso_n"}, miso_n, 0);
        chk({tag, "_state"},  32'(dut.state), 32'(DONE));
    endtask

    initial begin
        reset = 1'b1; cs = 1'b1; rw_flag = 1'b0;
        sclk_posedge = 1'b0; sclk_negedge = 1'b0;
        rec_clear();
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_outs", {addr_we, sr_we, dm_we, miso_buff}, 4'b0000);
`ifdef SPI_FSM_XFER_COUNT_EN
        chk("rst_xfer_count", xfer_count, 0);
`endif
        reset = 1'b0;
        cyc(1'b0, 1'b0);

        // Write 0xA5 to address 0x12, then stray edges while parked in DONE.
        rec_clear();
        cs = 1'b0;
        cyc(1'b0, 1'b0);
        send_byte(8'h24); p8 = last_pos;
        send_byte(8'hA5); p16 = last_pos;
        check_write("wr");
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        chk("done_stray_state", 32'(dut.state), 32'(DONE));
        chk("done_stray_strobes", addr_n + sr_n + dm_n + miso_n, 2);
        cs = 1'b1;
        cyc(1'b0, 1'b0);
        chk("wr_end_idle", 32'(dut.state), 32'(IDLE));

        // Read from 0x12 after a one-cycle cs-high gap.
        rec_clear();
        cs = 1'b0;
        cyc(1'b0, 1'b0);
        send_byte(8'h25); p8 = last_pos;
        send_byte(8'h00); p16 = last_pos;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        chk("rd_addr_n", addr_n, 1);
        chk("rd_addr_t", addr_t, p8);
        chk("rd_sr_n", sr_n, 1);
        chk("rd_sr_t", sr_t, p8 + 2);
        chk("rd_miso_first", miso_first, p8 + 3);
        chk("rd_miso_last", miso_last, p16 + 1);
        chk("rd_miso_n", miso_n, 31);
        chk("rd_dm_n", dm_n, 0);
        chk("rd_state", 32'(dut.state), 32'(DONE));
        cs = 1'b1;
        cyc(1'b0, 1'b0);

        // Abort a write after 12 posedges.
        rec_clear();
        cs = 1'b0;
        cyc(1'b0, 1'b0);
        send_byte(8'h24);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        chk("ab_in_shift", 32'(dut.state), 32'(WRITE_SHIFT));
        cs = 1'b1;
        cyc(1'b0, 1'b0);
        chk("ab_idle", 32'(dut.state), 32'(IDLE));
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        chk("ab_dm_n", dm_n, 0);
        chk("ab_addr_n", addr_n, 1);

        // Write to 0x13; the posedge coincident with the cs fall must not count.
        rec_clear();
        cs = 1'b0;
        cyc(1'b1, 1'b0);
        send_byte(8'h26); p8 = last_pos;
        send_byte(8'h3C); p16 = last_pos;
        check_write("wr13");
`ifdef SPI_FSM_XFER_COUNT_EN
        chk("xfer_count_3", xfer_count, 3);
`endif
        cs = 1'b1;
        cyc(1'b0, 1'b0);

        // Reset in the middle of a read data phase.
        rec_clear();
        cs = 1'b0;
        cyc(1'b0, 1'b0);
        send_byte(8'h25);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        chk("mid_rd_miso", miso_buff, 1'b1);
        reset = 1'b1;
        cs = 1'b1;
        cyc(1'b1, 1'b0);
        chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
        chk("mid_rst_outs", {addr_we, sr_we, dm_we, miso_buff}, 4'b0000);
`ifdef SPI_FSM_XFER_COUNT_EN
        chk("mid_rst_xfer_count", xfer_count, 0);
`endif
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
        chk("mid_rst_sr_n", sr_n, 1);
        chk("mid_rst_dm_n", dm_n, 0);
        chk("mid_rst_idle", 32'(dut.state), 32'(IDLE));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
